// File: rtl/uart_fifoed_recv.sv
// 8N1 UART receiver feeding a show-ahead circular FIFO of received bytes.
// Framing and overrun faults are reported as single-cycle registered pulses.
module uart_fifoed_recv #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       RX,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            push, fe_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push_ok, pop;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Samples fall mid-bit: the half-bit load in IDLE centres every later sample.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    fe_n      = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = HALF_BIT;
      end
      START: if (cnt == '0) begin
        if (!rx_s) begin
          state_n   = DATA;
          cnt_n     = FULL_BIT;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end else cnt_n = cnt - 1'b1;
      DATA: if (cnt == '0) begin
        shift_n = {rx_s, shift[7:1]};
        cnt_n   = FULL_BIT;
        if (bit_idx == 3'd7) state_n = STOP;
        else bit_idx_n = bit_idx + 1'b1;
      end else cnt_n = cnt - 1'b1;
      STOP: if (cnt == '0) begin
        if (rx_s) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          fe_n    = 1'b1;
          state_n = WAIT_HIGH;
        end
      end else cnt_n = cnt - 1'b1;
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Fullness is judged before the same-cycle pop, so a full FIFO drops the push.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign push_ok    = push && !fifo_full;
  assign pop        = rd_en && !fifo_empty;
  assign dout       = mem[rd_ptr];

  always_ff @(posedge clk_100MHz) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_n;
      overrun   <= push && fifo_full;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifoed_recv.sv
// Directed + randomized bench for uart_fifoed_recv against a queue-based byte model.
module tb_uart_fifoed_recv;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  // edge index (from the negedge driving the start bit) on which the stop bit is sampled
  localparam int STOP_EDGE = 3 + CPB/2 + 9*CPB;

  logic       clk_100MHz = 1'b0;
  logic       reset, RX, rd_en;
  logic [7:0] dout;
  logic       fifo_empty, fifo_full, frame_err, overrun;

  int checks = 0, errors = 0;
  int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] q[$];

  uart_fifoed_recv #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .RX(RX), .rd_en(rd_en),
    .dout(dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pulses must be single-cycle and never coincide
  always @(negedge clk_100MHz) begin
    if (reset) begin
      fe_prev = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (frame_err || overrun)
        check("pulse_shape", {29'd0, frame_err && overrun, frame_err && fe_prev, overrun && ov_prev}, 32'd0);
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
      fe_prev = frame_err;
      ov_prev = overrun;
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_empty"}, fifo_empty, q.size() == 0);
    check({tag, "_full"}, fifo_full, q.size() == DEPTH);
    if (q.size() > 0) check({tag, "_dout"}, dout, q[0]);
    check({tag, "_fe_cnt"}, fe_seen, fe_exp);
    check({tag, "_ov_cnt"}, ov_seen, ov_exp);
  endtask

  // one frame; rd_idx >= 0 raises rd_en for the single cycle ending at that edge
  task automatic send(input logic [7:0] b, input bit good, input int low_hold, input int rd_idx);
    logic [9:0] f;
    bit was_full;
    f = {good, b, 1'b0};
    was_full = (q.size() >= DEPTH);
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk_100MHz);
      RX = f[k/CPB];
      rd_en = (k == rd_idx);
    end
    @(negedge clk_100MHz);
    rd_en = 1'b0;
    if (!good) repeat (low_hold) @(negedge clk_100MHz);
    RX = 1'b1;
    repeat (2*CPB) @(negedge clk_100MHz);
    if (rd_idx >= 0 && q.size() > 0) void'(q.pop_front());
    if (!good) fe_exp++;
    else if (was_full) ov_exp++;
    else q.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk_100MHz);
    check({tag, "_pop_empty"}, fifo_empty, 1'b0);
    if (q.size() > 0) check({tag, "_pop_dout"}, dout, q[0]);
    rd_en = 1'b1;
    @(negedge clk_100MHz);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_empty"}, fifo_empty, 1'b1);
    check({tag, "_full"}, fifo_full, 1'b0);
    check({tag, "_fe"}, frame_err, 1'b0);
    check({tag, "_ov"}, overrun, 1'b0);
  endtask

  initial begin
    logic [9:0] f;
    RX = 1'b1; rd_en = 1'b0; reset = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    reset_outputs("rst");
    reset = 1'b0;
    repeat (4) @(negedge clk_100MHz);

    send(8'hA5, 1'b1, 0, -1);
    check_state("a5");
    pop_check("a5");
    check_state("a5_read");

    // short low pulse: start sample sees high again
    @(negedge clk_100MHz); RX = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    RX = 1'b1;
    repeat (3*CPB) @(negedge clk_100MHz);
    check_state("glitch");

    send(8'h3C, 1'b0, 5000, -1);
    check_state("frame_err");
    send(8'h11, 1'b1, 0, -1);
    check_state("after_break");
    pop_check("x11");

    @(negedge clk_100MHz); rd_en = 1'b1;
    @(negedge clk_100MHz); rd_en = 1'b0;
    check_state("rd_empty");

    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1, 0, -1);
      check_state("fill");
    end
    for (int i = 0; i < 16; i++) pop_check("drain");
    check_state("drained");

    for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)), 1'b1, 0, -1);
    check_state("refill");
    send(8'hEE, 1'b1, 0, STOP_EDGE - 1);
    check_state("full_rd");
    while (q.size() > 0) pop_check("drain2");

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1, 0, -1);
      check_state("rand");
      for (int j = $urandom_range(0, 2); j > 0 && q.size() > 0; j--) pop_check("rand");
    end
    while (q.size() > 0) pop_check("drain3");

    send(8'h77, 1'b1, 0, -1);
    check_state("pre_rst");
    f = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 5*CPB + CPB/2; k++) begin
      @(negedge clk_100MHz);
      RX = f[k/CPB];
    end
    reset = 1'b1; RX = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    reset_outputs("mid_rst");
    q.delete();
    reset = 1'b0;
    repeat (2*CPB) @(negedge clk_100MHz);
    check_state("post_rst");
    send(8'h5A, 1'b1, 0, -1);
    check_state("x5a");
    pop_check("x5a");
    check_state("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
